blink_sequencer: RTL and testbench

//  Plays a loaded on/off pattern onto one output pin, MSB-first, one bit per prescaled tick.

---
 rtl/blink_pkg.sv | 12 +
 rtl/tick_prescaler.sv | 31 +++
 rtl/blink_sequencer.sv | 137 +++++++++++++
 tb/tb_blink_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared constants for the blink sequencer: FSM state encoding and default timing.
package blink_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // 2^21 cycles at 16 MHz gives roughly 131 ms per pattern bit.
    localparam int DEF_TICK_DIV  = 2097152;
    localparam int DEF_GAP_TICKS = 7;

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a single-cycle tick every DIV cycles while enabled.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Held at zero while disabled so every play starts on a full bit period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/blink_sequencer.sv
// Plays a latched on/off pattern MSB-first onto one pin, one bit per prescaled tick,
// with optional repeats separated by a fixed dark gap.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int MAX_LEN   = 35,
    parameter int LEN_W     = 6,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int REP_W     = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    input  logic [REP_W-1:0]   repeat_count,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               out,
    output logic [LEN_W-1:0]   bit_idx
);

    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

    logic [1:0]         state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [REP_W-1:0]   reps;
    logic [GAP_W-1:0]   gap_cnt;
    logic               tick;

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   start_idx;
    logic [LEN_W-1:0]   last_idx;
    logic [LEN_W-1:0]   next_idx;

    assign len_clamped = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
    assign start_idx   = len_clamped - 1'b1;
    assign last_idx    = len_q - 1'b1;
    assign next_idx    = idx - 1'b1;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    // out is registered and updated on the same edge that moves idx, so the pin
    // changes exactly on bit boundaries. abort takes priority over everything,
    // including a start arriving in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            reps    <= '0;
            gap_cnt <= '0;
            out     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                idx   <= '0;
                out   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len_clamped == '0) begin
                                done <= 1'b1;
                            end else begin
                                pat_q <= pattern;
                                len_q <= len_clamped;
                                reps  <= repeat_count;
                                idx   <= start_idx;
                                out   <= pattern[start_idx];
                                state <= ST_PLAY;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            if (idx != '0) begin
                                idx <= next_idx;
                                out <= pat_q[next_idx];
                            end else if (reps != '0) begin
                                reps <= reps - 1'b1;
                                if (GAP_TICKS > 0) begin
                                    state   <= ST_GAP;
                                    gap_cnt <= GAP_RELOAD;
                                    out     <= 1'b0;
                                end else begin
                                    idx <= last_idx;
                                    out <= pat_q[last_idx];
                                end
                            end else begin
                                state <= ST_IDLE;
                                out   <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (tick) begin
                            if (gap_cnt == '0) begin
                                state <= ST_PLAY;
                                idx   <= last_idx;
                                out   <= pat_q[last_idx];
                            end else begin
                                gap_cnt <= gap_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        out   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready   = (state == ST_IDLE);
    assign busy    = ~ready;
    assign bit_idx = idx;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed and scoreboard bench for blink_sequencer with a short tick (4) and gap (2).
module tb_blink_sequencer;

    localparam int DIV = 4;
    localparam int GAP = 2;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        abort;
    logic [34:0] pattern;
    logic [5:0]  length;
    logic [3:0]  repeat_count;
    logic        ready;
    logic        busy;
    logic        done;
    logic        out;
    logic [5:0]  bit_idx;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [34:0] pat;
        logic [5:0]  len;
        logic [3:0]  rep;
        bit          hold;
        int          exp_busy;
        int          exp_ones;
        int          exp_first;
    } vec_t;

    vec_t vecs[8];

    blink_sequencer #(
        .MAX_LEN   (35),
        .LEN_W     (6),
        .TICK_DIV  (DIV),
        .GAP_TICKS (GAP),
        .REP_W     (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .abort        (abort),
        .pattern      (pattern),
        .length       (length),
        .repeat_count (repeat_count),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .out          (out),
        .bit_idx      (bit_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one play, scrambles the inputs after acceptance and measures the run.
    task automatic apply_stimulus(input vec_t v, output int busy_n, output int ones_n,
                                  output int first_o, output int done_n, output int done_at);
        pattern      = v.pat;
        length       = v.len;
        repeat_count = v.rep;
        start        = 1'b1;
        step(1);
        pattern      = ~v.pat;
        length       = 6'd1;
        repeat_count = 4'd9;
        start        = v.hold;
        busy_n  = 0;
        ones_n  = 0;
        done_n  = 0;
        done_at = -1;
        first_o = int'(out);
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (!busy) break;
            busy_n++;
            if (out) ones_n++;
            step(1);
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(1);
            if (done) done_n++;
        end
    endtask

    // Reference model: builds the expected per-cycle pin and index trace, then compares.
    task automatic run_scoreboard(input int n, input logic [34:0] pat, input int len, input int rep);
        bit out_q[$];
        int idx_q[$];
        int formula;
        int c;
        for (int p = 0; p <= rep; p++) begin
            if (p > 0) begin
                for (int g = 0; g < GAP * DIV; g++) begin
                    out_q.push_back(1'b0);
                    idx_q.push_back(0);
                end
            end
            for (int i = len - 1; i >= 0; i--) begin
                for (int t = 0; t < DIV; t++) begin
                    out_q.push_back(pat[i]);
                    idx_q.push_back(i);
                end
            end
        end
        formula = (rep + 1) * len * DIV + rep * GAP * DIV;
        pattern      = pat;
        length       = 6'(len);
        repeat_count = 4'(rep);
        start        = 1'b1;
        step(1);
        start   = 1'b0;
        pattern = '0;
        c = 0;
        while (busy && c < formula + 10) begin
            if (c < out_q.size()) begin
                check_output($sformatf("sb%0d out c%0d", n, c), int'(out), int'(out_q[c]));
                check_output($sformatf("sb%0d idx c%0d", n, c), int'(bit_idx), idx_q[c]);
            end
            check_output($sformatf("sb%0d done c%0d", n, c), int'(done), 0);
            c++;
            step(1);
        end
        check_output($sformatf("sb%0d busy_cycles", n), c, formula);
        check_output($sformatf("sb%0d done_end", n), int'(done), 1);
        check_output($sformatf("sb%0d out_end", n), int'(out), 0);
        step(1);
    endtask

    initial begin
        int busy_n, ones_n, first_o, done_n, done_at, cnt;
        logic [63:0] rnd;

        vecs[0] = '{35'b10101000, 6'd8, 4'd0, 1'b0, 32, 12, 1};
        vecs[1] = '{35'b110, 6'd3, 4'd1, 1'b1, 32, 16, 1};
        vecs[2] = '{35'h1, 6'd0, 4'd0, 1'b0, 0, 0, 0};
        vecs[3] = '{35'h400000001, 6'd63, 4'd0, 1'b0, 140, 8, 1};
        vecs[4] = '{35'b01011, 6'd5, 4'd2, 1'b0, 76, 36, 0};
        vecs[5] = '{35'b1, 6'd1, 4'd15, 1'b0, 184, 64, 1};
        vecs[6] = '{35'h7FFFFFFFF, 6'd35, 4'd0, 1'b0, 140, 140, 1};
        vecs[7] = '{35'hF0, 6'd4, 4'd0, 1'b0, 16, 0, 0};

        RST = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pattern = '0;
        length = '0;
        repeat_count = '0;
        step(3);
        check_output("reset ready", int'(ready), 1);
        check_output("reset busy", int'(busy), 0);
        check_output("reset out", int'(out), 0);
        check_output("reset done", int'(done), 0);
        check_output("reset bit_idx", int'(bit_idx), 0);
        RST = 1'b0;
        step(2);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i], busy_n, ones_n, first_o, done_n, done_at);
            check_output($sformatf("vec%0d busy_cycles", i), busy_n, vecs[i].exp_busy);
            check_output($sformatf("vec%0d on_cycles", i), ones_n, vecs[i].exp_ones);
            check_output($sformatf("vec%0d first_out", i), first_o, vecs[i].exp_first);
            check_output($sformatf("vec%0d done_pulses", i), done_n, 1);
            check_output($sformatf("vec%0d done_cycle", i), done_at, vecs[i].exp_busy + 1);
        end

        // Back-to-back: start held through the done cycle launches a second play at once.
        pattern = 35'b101;
        length = 6'd3;
        repeat_count = 4'd0;
        start = 1'b1;
        step(13);
        check_output("b2b done", int'(done), 1);
        check_output("b2b ready", int'(ready), 1);
        check_output("b2b out_done", int'(out), 0);
        step(1);
        start = 1'b0;
        check_output("b2b busy2", int'(busy), 1);
        check_output("b2b out2", int'(out), 1);
        check_output("b2b idx2", int'(bit_idx), 2);
        step(12);
        check_output("b2b done2", int'(done), 1);
        step(2);

        // Abort in cycle 10 of the single-play pattern.
        pattern = 35'b10101000;
        length = 6'd8;
        repeat_count = 4'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        check_output("abort pre_out", int'(out), 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check_output("abort out", int'(out), 0);
        check_output("abort ready", int'(ready), 1);
        check_output("abort busy", int'(busy), 0);
        check_output("abort bit_idx", int'(bit_idx), 0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) cnt++;
            step(1);
        end
        check_output("abort no_done", cnt, 0);

        // start and abort together while idle must not launch a play.
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check_output("start_abort ready", int'(ready), 1);
        check_output("start_abort out", int'(out), 0);
        check_output("start_abort done", int'(done), 0);
        step(4);
        check_output("start_abort still_idle", int'(busy), 0);

        // Asynchronous reset mid-play.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        check_output("rst pre_out", int'(out), 1);
        check_output("rst pre_busy", int'(busy), 1);
        #1;
        RST = 1'b1;
        #1;
        check_output("rst out", int'(out), 0);
        check_output("rst ready", int'(ready), 1);
        check_output("rst bit_idx", int'(bit_idx), 0);
        check_output("rst done", int'(done), 0);
        step(1);
        RST = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done || busy) cnt++;
            step(1);
        end
        check_output("rst stays_idle", cnt, 0);

        run_scoreboard(100, 35'b10101000, 8, 0);
        run_scoreboard(101, 35'b110, 3, 1);
        for (int n = 0; n < 20; n++) begin
            rnd = {$urandom, $urandom};
            run_scoreboard(n, rnd[34:0], $urandom_range(1, 35), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
